led_frame_scanner: RTL and testbench

- Display-side reader of the game state produced by the brick/score logic.
- Consumes the `Bricks[71:0]` bitmap, ball position, paddle position, `score[9:0]` and `IsGameOver`, and drives two displays:
  - a 16x16 row-multiplexed LED dot matrix;
  - a 4-digit multiplexed 7-segment score display.
- Snapshots all inputs once per frame so the picture never tears mid-scan.
- Converts the score to BCD with a sequential double-dabble engine.

---
 rtl/led_frame_scanner.sv | 224 ++++++++++++++++++++++
 tb/tb_led_frame_scanner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scanner.sv
// led_frame_scanner
//   Display-side reader of the brick game state. Once per frame it snapshots
//   the brick bitmap, ball, paddle, score and game-over flag. It then scans a
//   16x16 row-multiplexed LED matrix and a 4-digit multiplexed 7-segment score
//   display. A sequential double-dabble engine converts the score to BCD.
//
// Ports
//   clock, reset            : system clock, asynchronous active-high reset
//   Bricks[71:0]            : brick bitmap; bit k lights row k/8+1, cols 2*(k%8)+{0,1}
//   Ball_rowIndex/colIndex  : ball position
//   Paddle_colIndex         : leftmost paddle column
//   score[9:0]              : current score
//   IsGameOver              : game-over flag
//   row_n[15:0]             : active-low one-hot row select
//   col[15:0]               : active-high column data
//   seg[6:0]                : active-low segments, gfedcba
//   digit_sel[3:0]          : active-low one-hot digit select, bit 0 = units
//   frame_start             : one-cycle pulse in the LOAD cycle
module led_frame_scanner #(
    parameter int ROW_DWELL    = 1000,
    parameter int PADDLE_ROW   = 15,
    parameter int PADDLE_WIDTH = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [71:0] Bricks,
    input  logic [3:0]  Ball_rowIndex,
    input  logic [3:0]  Ball_colIndex,
    input  logic [3:0]  Paddle_colIndex,
    input  logic [9:0]  score,
    input  logic        IsGameOver,
    output logic [15:0] row_n,
    output logic [15:0] col,
    output logic [6:0]  seg,
    output logic [3:0]  digit_sel,
    output logic        frame_start
);
    localparam int KW   = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
    localparam int FC_W = 16;

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [3:0]      row_q, row_d;
    logic [KW-1:0]   dwell_q, dwell_d;
    logic [FC_W-1:0] frame_q, frame_d;
    logic [3:0]      bcd_cnt_q, bcd_cnt_d;
    logic [15:0]     digits_q, digits_d;
    logic [9:0]      last_score_q, last_score_d;
    logic [15:0]     row_n_q, row_n_d;
    logic [15:0]     col_q, col_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      dsel_q, dsel_d;
    logic            fs_q, fs_d;

    // Per-frame snapshots and the BCD shift register (data, no reset needed)
    logic [71:0]     bricks_q;
    logic [3:0]      ball_r_q, ball_c_q, pad_q;
    logic            go_q;
    logic [25:0]     bcd_sh_q;

    logic [25:0]     bcd_next;
    logic [9:0]      score_sel;
    logic [FC_W-1:0] blink_div;
    logic [7:0]      brick_byte;
    logic [4:0]      pad_end;
    logic [15:0]     pix;
    logic [3:0]      cur_digit;

    // One double-dabble iteration: [25:10] hold four BCD digits, [9:0] the binary
    function automatic logic [25:0] dd_step(input logic [25:0] v);
        logic [25:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[10+4*i +: 4] >= 4'd5)
                t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign bcd_next  = dd_step(bcd_sh_q);
    // The score source clears together with the game-over flag, so while the
    // flag is up the last pre-game-over score is used instead.
    assign score_sel = IsGameOver ? last_score_q : score;
    assign blink_div = frame_q / FC_W'(BLINK_FRAMES);
    assign cur_digit = digits_q[{row_q[1:0], 2'b00} +: 4];

    always_comb begin
        brick_byte = 8'h00;
        for (int b = 0; b < 9; b++) begin
            if (row_q == 4'(b + 1))
                brick_byte = bricks_q[b*8 +: 8];
        end
        // 5-bit sum so a paddle near the right edge clips instead of wrapping
        pad_end = {1'b0, pad_q} + 5'(PADDLE_WIDTH);
        pix     = '0;
        for (int j = 0; j < 16; j++) begin
            pix[j] = brick_byte[j/2]
                   | ((row_q == ball_r_q) && (4'(j) == ball_c_q))
                   | ((row_q == 4'(PADDLE_ROW)) && (5'(j) >= {1'b0, pad_q}) && (5'(j) < pad_end));
        end
        if (go_q)
            pix = {16{blink_div[0]}};
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        dwell_d      = dwell_q;
        frame_d      = frame_q;
        bcd_cnt_d    = bcd_cnt_q;
        digits_d     = digits_q;
        last_score_d = score_sel;
        row_n_d      = 16'hFFFF;
        col_d        = 16'h0000;
        seg_d        = 7'h7F;
        dsel_d       = 4'hF;
        fs_d         = 1'b0;

        // All four digits are committed together after the tenth shift
        if (bcd_cnt_q != 4'd0) begin
            bcd_cnt_d = bcd_cnt_q - 4'd1;
            if (bcd_cnt_q == 4'd1)
                digits_d = bcd_next[25:10];
        end

        case (state_q)
            S_LOAD: begin
                frame_d   = frame_q + 1'b1;
                fs_d      = 1'b1;
                bcd_cnt_d = 4'd10;
                row_d     = 4'd0;
                dwell_d   = '0;
                state_d   = S_SCAN;
            end
            default: begin
                row_n_d = ~(16'd1 << row_q);
                // dwell 0 is the ghost-blanking slot after a row change
                if (dwell_q != '0) begin
                    col_d  = pix;
                    dsel_d = ~(4'd1 << row_q[1:0]);
                    seg_d  = seg_enc(cur_digit);
                end
                if (dwell_q == KW'(ROW_DWELL - 1)) begin
                    dwell_d = '0;
                    if (row_q == 4'd15)
                        state_d = S_LOAD;
                    else
                        row_d = row_q + 4'd1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            row_q        <= 4'd0;
            dwell_q      <= '0;
            frame_q      <= '0;
            bcd_cnt_q    <= 4'd0;
            digits_q     <= 16'h0000;
            last_score_q <= 10'd0;
            row_n_q      <= 16'hFFFF;
            col_q        <= 16'h0000;
            seg_q        <= 7'h7F;
            dsel_q       <= 4'hF;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            dwell_q      <= dwell_d;
            frame_q      <= frame_d;
            bcd_cnt_q    <= bcd_cnt_d;
            digits_q     <= digits_d;
            last_score_q <= last_score_d;
            row_n_q      <= row_n_d;
            col_q        <= col_d;
            seg_q        <= seg_d;
            dsel_q       <= dsel_d;
            fs_q         <= fs_d;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == S_LOAD) begin
            bricks_q <= Bricks;
            ball_r_q <= Ball_rowIndex;
            ball_c_q <= Ball_colIndex;
            pad_q    <= Paddle_colIndex;
            go_q     <= IsGameOver;
            bcd_sh_q <= {16'd0, score_sel};
        end else if (bcd_cnt_q != 4'd0) begin
            bcd_sh_q <= bcd_next;
        end
    end

    assign row_n       = row_n_q;
    assign col         = col_q;
    assign seg         = seg_q;
    assign digit_sel   = dsel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_led_frame_scanner.sv
module tb_led_frame_scanner;
    localparam int RD    = 12;
    localparam int FRAME = 16*RD + 1;

    logic        clock;
    logic        reset;
    logic [71:0] Bricks;
    logic [3:0]  Ball_rowIndex, Ball_colIndex, Paddle_colIndex;
    logic [9:0]  score;
    logic        IsGameOver;
    logic [15:0] row_n, col;
    logic [6:0]  seg;
    logic [3:0]  digit_sel;
    logic        frame_start;

    led_frame_scanner #(.ROW_DWELL(RD)) dut (
        .clock(clock), .reset(reset), .Bricks(Bricks),
        .Ball_rowIndex(Ball_rowIndex), .Ball_colIndex(Ball_colIndex),
        .Paddle_colIndex(Paddle_colIndex), .score(score), .IsGameOver(IsGameOver),
        .row_n(row_n), .col(col), .seg(seg), .digit_sel(digit_sel),
        .frame_start(frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model state
    int          ecount;
    int          m_frame;
    int          m_score_cur, m_score_prev, m_last;
    logic [71:0] m_bricks;
    int          m_br, m_bc, m_pc;
    logic        m_go;
    logic [43:0] sb_q[$];
    logic [43:0] got, want;
    int          mp;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] exp_pix(input int r);
        logic [15:0] v;
        v = '0;
        if (m_go) return (((m_frame / 8) % 2) == 1) ? 16'hFFFF : 16'h0000;
        for (int j = 0; j < 16; j++) begin
            if (r >= 1 && r <= 9 && m_bricks[(r-1)*8 + j/2]) v[j] = 1'b1;
            if (r == m_br && j == m_bc) v[j] = 1'b1;
            if (r == 15 && j >= m_pc && j < m_pc + 4) v[j] = 1'b1;
        end
        return v;
    endfunction

    // Expected {row_n, col, seg, digit_sel, frame_start} for frame position p
    function automatic logic [43:0] exp_out(input int p);
        int s, r, k, d, sc, dv;
        logic [15:0] rown;
        if (p == 0) return {16'hFFFF, 16'h0000, 7'h7F, 4'hF, 1'b1};
        s = p - 1;
        r = s / RD;
        k = s % RD;
        rown = ~(16'd1 << r);
        if (k == 0) return {rown, 16'h0000, 7'h7F, 4'hF, 1'b0};
        d  = r % 4;
        // new BCD digits are visible from position 11 of the frame onward
        sc = (p >= 11) ? m_score_cur : m_score_prev;
        dv = sc;
        for (int i = 0; i < d; i++) dv = dv / 10;
        dv = dv % 10;
        return {rown, exp_pix(r), pat(dv), ~(4'd1 << d), 1'b0};
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            ecount       = 0;
            m_frame      = 0;
            m_score_cur  = 0;
            m_score_prev = 0;
            m_last       = 0;
            m_go         = 1'b0;
            sb_q.delete();
        end else begin
            mp = ecount % FRAME;
            if (mp == 0) begin
                m_frame++;
                m_score_prev = m_score_cur;
                m_bricks     = Bricks;
                m_br         = int'(Ball_rowIndex);
                m_bc         = int'(Ball_colIndex);
                m_pc         = int'(Paddle_colIndex);
                m_go         = IsGameOver;
                m_score_cur  = IsGameOver ? m_last : int'(score);
            end
            if (!IsGameOver) m_last = int'(score);
            sb_q.push_back(exp_out(mp));
            ecount++;
            #1;
            want = sb_q.pop_front();
            got  = {row_n, col, seg, digit_sel, frame_start};
            // segment lines are don't-care while no digit is selected
            if (want[4:1] == 4'hF) got[11:5] = want[11:5];
            chk($sformatf("out frame%0d pos%0d", m_frame, mp), 64'(got), 64'(want));
        end
    end

    task automatic wait_ec(input int target);
        int budget;
        budget = 0;
        while (ecount < target && budget < 6000) begin
            @(negedge clock);
            budget++;
        end
        if (ecount < target)
            chk("wait_timeout", 64'(ecount), 64'(target));
    endtask

    task automatic chk_blank(input string tag);
        chk(tag, 64'({row_n, col, seg, digit_sel, frame_start}),
                 64'({16'hFFFF, 16'h0000, 7'h7F, 4'hF, 1'b0}));
    endtask

    initial begin
        reset = 1'b1;
        Bricks = '0; Ball_rowIndex = '0; Ball_colIndex = '0;
        Paddle_colIndex = '0; score = '0; IsGameOver = 1'b0;
        repeat (3) @(negedge clock);
        chk_blank("reset_state");
        reset = 1'b0;

        // frame 1 all zero; frame 2 bricks 0/71, ball (12,5), paddle 14, score 1023
        wait_ec(100);
        Bricks = 72'd0;
        Bricks[0] = 1'b1;
        Bricks[71] = 1'b1;
        Ball_rowIndex = 4'd12; Ball_colIndex = 4'd5;
        Paddle_colIndex = 4'd14; score = 10'd1023;

        // asynchronous reset in the middle of row 7 of frame 3
        wait_ec(2*FRAME + 1 + 7*RD + 5);
        #2 reset = 1'b1;
        #1 chk_blank("async_reset_now");
        @(posedge clock);
        #1 chk_blank("async_reset_held");
        @(negedge clock);
        reset = 1'b0;

        // restart: frame 1 shows 1023; mid-frame changes for frame 2
        wait_ec(100);
        Bricks = {8'($urandom), 32'($urandom), 32'($urandom)};
        Ball_rowIndex = 4'd3; Ball_colIndex = 4'd7;
        Paddle_colIndex = 4'd0; score = 10'd5;

        wait_ec(FRAME + 60);
        score = 10'd7;
        Bricks = {8'($urandom), 32'($urandom), 32'($urandom)};
        Ball_rowIndex = 4'd15; Ball_colIndex = 4'd15;
        Paddle_colIndex = 4'd13;

        wait_ec(2*FRAME + 150);
        score = 10'd42;

        // game over and score clear in the same cycle
        wait_ec(3*FRAME + 50);
        IsGameOver = 1'b1;
        score = 10'd0;
        Ball_rowIndex = 4'd1; Ball_colIndex = 4'd1;

        wait_ec(18*FRAME + 20);
        IsGameOver = 1'b0;
        score = 10'd999;
        Bricks = {8'($urandom), 32'($urandom), 32'($urandom)};
        Ball_rowIndex = 4'd0; Ball_colIndex = 4'd0;
        Paddle_colIndex = 4'd12;

        wait_ec(20*FRAME + 5);
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
